// File: rtl/tmp121_spi_slave_pkg.sv
// Shared constants and types for the TMP121 SPI sensor emulator.
//   TEMP_W       width of the two's-complement temperature field
//   FRAME_BITS   bits per sensor frame (temperature + status tail)
//   DEFAULT_TAIL status bits appended after the temperature
//   state_t      responder FSM states
package tmp121_pkg;

    localparam int unsigned TEMP_W       = 13;
    localparam int unsigned FRAME_BITS   = 16;
    localparam logic [2:0]  DEFAULT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } state_t;

endpackage

// File: rtl/tmp121_spi_slave_if.sv
// Bus bundle between the SPI master / register writer and the TMP121 emulator.
//   csn, sck            SPI pins from the master (asynchronous to clk)
//   miso, miso_oe       serial data and tristate enable back to the master
//   temp_in, temp_we    temperature register write port
//   frame_done/short    end-of-frame status pulses
interface tmp121_spi_slave_if;
    import tmp121_pkg::*;

    logic              csn;
    logic              sck;
    logic              miso;
    logic              miso_oe;
    logic [TEMP_W-1:0] temp_in;
    logic              temp_we;
    logic              frame_done;
    logic              frame_short;

    modport slave (
        input  csn, sck, temp_in, temp_we,
        output miso, miso_oe, frame_done, frame_short
    );

    modport master (
        output csn, sck, temp_in, temp_we,
        input  miso, miso_oe, frame_done, frame_short
    );

endinterface

// File: rtl/tmp121_spi_slave_sync_edge.sv
// Synchroniser plus registered edge detector for one asynchronous pin.
//   clk, rst   system clock, synchronous active-high reset
//   d          asynchronous pin
//   q          synchronised level (SYNC_STAGES flops after d)
//   rise/fall  one-cycle edge flags, SYNC_STAGES+1 clocks after the pin edge
// RST_VAL should match the pin's idle level so reset never fabricates an edge.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    // One extra stage beyond the synchroniser holds the previous level.
    logic [SYNC_STAGES:0] r_sync;
    logic                 r_rise;
    logic                 r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {(SYNC_STAGES + 1){RST_VAL}};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-1:0], d};
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/tmp121_spi_slave.sv
// TMP121 temperature sensor emulator: answers an SPI read with a 16-bit frame
// {temperature[12:0], TAIL_BITS}, MSB first, data changing on falling sck.
//   clk, rst   system clock, synchronous active-high reset
//   bus        tmp121_spi_slave_if.slave (SPI pins, temp write port, status)
// Parameters: SYNC_STAGES (2..4) pin synchroniser depth, TAIL_BITS status bits.
module tmp121_spi_slave
    import tmp121_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  TAIL_BITS   = DEFAULT_TAIL
) (
    input logic               clk,
    input logic               rst,
    tmp121_spi_slave_if.slave bus
);

    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_sck_q, w_sck_rise, w_sck_fall;
    logic w_unused_sck;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.csn),
        .q    (w_cs_q),
        .rise (w_cs_rise),
        .fall (w_cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sck),
        .q    (w_sck_q),
        .rise (w_sck_rise),
        .fall (w_sck_fall)
    );

    assign w_unused_sck = w_sck_q ^ w_sck_rise;

    state_t                r_state, w_state_nxt;
    logic [TEMP_W-1:0]     r_pend;
    logic [FRAME_BITS-1:0] r_shr, w_shr_nxt;
    logic [4:0]            r_bcnt, w_bcnt_nxt;
    logic                  r_miso, w_miso_nxt;
    logic                  r_miso_oe, w_miso_oe_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_short, w_short_nxt;
    logic [2:0]            r_settle;
    logic                  r_armed;

    // After reset the csn synchroniser holds its reset level, not the pin. Once it has
    // flushed, arm only when csn reads high so a frame already running is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= 3'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 3'(SYNC_STAGES)) begin
            r_settle <= r_settle + 3'd1;
        end else if (w_cs_q) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (bus.temp_we) begin
            r_pend <= bus.temp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shr     <= '0;
            r_bcnt    <= '0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shr     <= w_shr_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_miso    <= w_miso_nxt;
            r_miso_oe <= w_miso_oe_nxt;
            r_done    <= w_done_nxt;
            r_short   <= w_short_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shr_nxt   = r_shr;
        w_bcnt_nxt  = r_bcnt;
        w_done_nxt  = 1'b0;
        w_short_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A coincident sck fall is ignored here: the load wins.
                if (w_cs_fall && r_armed) begin
                    w_shr_nxt   = {r_pend, TAIL_BITS};
                    w_bcnt_nxt  = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Frame end beats a coincident shift.
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = (r_bcnt == 5'(FRAME_BITS));
                    w_short_nxt = (r_bcnt != 5'(FRAME_BITS));
                end else if (w_sck_fall) begin
                    w_shr_nxt  = {r_shr[FRAME_BITS-2:0], 1'b0};
                    w_bcnt_nxt = r_bcnt + 5'd1;
                    if (r_bcnt == 5'(FRAME_BITS - 1)) begin
                        w_state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = (r_bcnt == 5'(FRAME_BITS));
                    w_short_nxt = (r_bcnt != 5'(FRAME_BITS));
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Pin outputs are registered from the next state.
        w_miso_oe_nxt = (w_state_nxt != IDLE);
        w_miso_nxt    = (w_state_nxt == SHIFT) ? w_shr_nxt[FRAME_BITS-1] : 1'b0;
    end

    assign bus.miso        = r_miso;
    assign bus.miso_oe     = r_miso_oe;
    assign bus.frame_done  = r_done;
    assign bus.frame_short = r_short;

endmodule

// File: tb/tb_tmp121_spi_slave.sv
// Self-checking bench for tmp121_spi_slave: a master model clocks frames at
// clk/32 and the captured bits are compared with a frame model built from the
// last written temperature.
module tb_tmp121_spi_slave;

    logic clk;
    logic rst;

    tmp121_spi_slave_if bus();

    tmp121_spi_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_short  = 0;

    logic [12:0] m_pend;

    always @(negedge clk) begin
        if (bus.frame_done)  n_done++;
        if (bus.frame_short) n_short++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_temp(input logic [12:0] t);
        bus.temp_in = t;
        bus.temp_we = 1'b1;
        tick(1);
        bus.temp_we = 1'b0;
        m_pend      = t;
    endtask

    // Sensor frame as the master should see it: temperature then status bits.
    function automatic logic [15:0] model_word(input logic [12:0] t);
        return {t, 3'b100};
    endfunction

    // Bit k is the k-th bit on the wire; beyond 16 the sensor sends zeros.
    function automatic logic [31:0] model_bits(input logic [15:0] w, input int nbits);
        logic [31:0] e;
        e = '0;
        for (int k = 0; k < nbits; k++) e[k] = (k < 16) ? w[15-k] : 1'b0;
        return e;
    endfunction

    function automatic logic [15:0] word_of(input logic [31:0] cap);
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[15-k] = cap[k];
        return w;
    endfunction

    task automatic spi_frame(input int nbits, input bit coinc, input int wr_bit,
                             input logic [12:0] wr_val, input int rst_bit,
                             output logic [31:0] cap, output logic [31:0] oe_cap,
                             output int done_at, output int short_at);
        cap = '0; oe_cap = '0; done_at = 0; short_at = 0;
        if (coinc) begin
            bus.sck = 1'b1;
            tick(4);
        end
        bus.csn = 1'b0;
        bus.sck = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            tick(16);
            cap[k]    = bus.miso;
            oe_cap[k] = bus.miso_oe;
            bus.sck   = 1'b1;
            tick(16);
            bus.sck = 1'b0;
            if (k == wr_bit) begin
                tick(1);
                write_temp(wr_val);
            end
            if (k == rst_bit) begin
                tick(1);
                rst = 1'b1;
                tick(1);
                rst    = 1'b0;
                m_pend = '0;
            end
        end
        tick(8);
        bus.csn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (bus.frame_done && done_at == 0)   done_at = i;
            if (bus.frame_short && short_at == 0) short_at = i;
        end
        tick(10);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.csn = 1'b1; bus.sck = 1'b0; bus.temp_in = '0; bus.temp_we = 1'b0;
        m_pend = '0;
        tick(5);
        n_checks++;
        if (bus.miso_oe !== 1'b0) begin n_errors++; $display("FAIL reset_oe: got %b expected 0", bus.miso_oe); end
        n_checks++;
        if (bus.miso !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
        n_checks++;
        if ({bus.frame_done, bus.frame_short} !== 2'b00) begin
            n_errors++; $display("FAIL reset_pulses: got %b expected 00", {bus.frame_done, bus.frame_short});
        end
        rst = 1'b0;
        tick(10);
        n_checks++;
        if (bus.miso_oe !== 1'b0) begin n_errors++; $display("FAIL idle_oe: got %b expected 0", bus.miso_oe); end
    endtask

    task automatic test_value(input logic [12:0] t, input logic [15:0] want, input string name);
        logic [31:0] cap, oe; int da, sa, d0, s0;
        write_temp(t);
        d0 = n_done; s0 = n_short;
        spi_frame(16, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== want) begin n_errors++; $display("FAIL %s_word: got %h expected %h", name, word_of(cap), want); end
        n_checks++;
        if (word_of(cap) !== model_word(t)) begin
            n_errors++; $display("FAIL %s_model: got %h expected %h", name, word_of(cap), model_word(t));
        end
        n_checks++;
        if (word_of(cap) >> 3 !== 16'(t)) begin
            n_errors++; $display("FAIL %s_temp: got %h expected %h", name, word_of(cap) >> 3, t);
        end
        n_checks++;
        if (oe[15:0] !== 16'hFFFF) begin n_errors++; $display("FAIL %s_oe: got %h expected ffff", name, oe[15:0]); end
        n_checks++;
        if (da !== 4) begin n_errors++; $display("FAIL %s_done_at: got %0d expected 4", name, da); end
        n_checks++;
        if (n_done - d0 !== 1 || n_short - s0 !== 0) begin
            n_errors++; $display("FAIL %s_pulses: got done=%0d short=%0d expected done=1 short=0",
                                 name, n_done - d0, n_short - s0);
        end
    endtask

    task automatic test_latency;
        write_temp(13'h1000);
        bus.csn = 1'b0;
        tick(3);
        n_checks++;
        if (bus.miso_oe !== 1'b0) begin n_errors++; $display("FAIL lat_oe_early: got %b expected 0", bus.miso_oe); end
        tick(1);
        n_checks++;
        if ({bus.miso_oe, bus.miso} !== 2'b11) begin
            n_errors++; $display("FAIL lat_oe_miso: got %b expected 11", {bus.miso_oe, bus.miso});
        end
        bus.csn = 1'b1;
        tick(3);
        n_checks++;
        if (bus.frame_short !== 1'b0) begin n_errors++; $display("FAIL lat_short_early: got %b expected 0", bus.frame_short); end
        tick(1);
        n_checks++;
        if (bus.frame_short !== 1'b1) begin n_errors++; $display("FAIL lat_short: got %b expected 1", bus.frame_short); end
        tick(1);
        n_checks++;
        if (bus.frame_short !== 1'b0) begin n_errors++; $display("FAIL lat_short_once: got %b expected 0", bus.frame_short); end
        tick(10);
    endtask

    task automatic test_midframe_write;
        logic [31:0] cap, oe; int da, sa;
        write_temp(13'h0010);
        spi_frame(16, 1'b0, 5, 13'h0FFF, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== model_word(13'h0010)) begin
            n_errors++; $display("FAIL midwr_cur: got %h expected %h", word_of(cap), model_word(13'h0010));
        end
        spi_frame(16, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== model_word(m_pend)) begin
            n_errors++; $display("FAIL midwr_next: got %h expected %h", word_of(cap), model_word(m_pend));
        end
    endtask

    task automatic test_short;
        logic [31:0] cap, oe; int da, sa, d0, s0;
        write_temp(13'h0A5A);
        d0 = n_done; s0 = n_short;
        spi_frame(7, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (cap !== model_bits(model_word(m_pend), 7)) begin
            n_errors++; $display("FAIL short_bits: got %h expected %h", cap, model_bits(model_word(m_pend), 7));
        end
        n_checks++;
        if (sa !== 4 || da !== 0 || n_short - s0 !== 1 || n_done - d0 !== 0) begin
            n_errors++; $display("FAIL short_pulses: got short_at=%0d done_at=%0d expected 4 and 0", sa, da);
        end
        spi_frame(16, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== model_word(m_pend) || da !== 4) begin
            n_errors++; $display("FAIL short_then_full: got %h done_at=%0d expected %h done_at=4",
                                 word_of(cap), da, model_word(m_pend));
        end
    endtask

    task automatic test_coincident;
        logic [31:0] cap, oe; int da, sa;
        write_temp(13'h1555);
        spi_frame(16, 1'b1, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== model_word(m_pend)) begin
            n_errors++; $display("FAIL coinc_word: got %h expected %h", word_of(cap), model_word(m_pend));
        end
    endtask

    task automatic test_overclock;
        logic [31:0] cap, oe; int da, sa;
        write_temp(13'h0F0F);
        spi_frame(20, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (cap !== model_bits(model_word(m_pend), 20)) begin
            n_errors++; $display("FAIL over_bits: got %h expected %h", cap, model_bits(model_word(m_pend), 20));
        end
        n_checks++;
        if (cap[19:16] !== 4'h0) begin n_errors++; $display("FAIL over_tail: got %h expected 0", cap[19:16]); end
        n_checks++;
        if (da !== 4 || sa !== 0) begin
            n_errors++; $display("FAIL over_done: got done_at=%0d short_at=%0d expected 4 and 0", da, sa);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] cap, oe; int da, sa, d0, s0;
        write_temp(13'h1234);
        d0 = n_done; s0 = n_short;
        spi_frame(16, 1'b0, -1, '0, 8, cap, oe, da, sa);
        n_checks++;
        if (oe[15:9] !== 7'h00) begin n_errors++; $display("FAIL rstmid_oe: got %h expected 00", oe[15:9]); end
        n_checks++;
        if (oe[8:0] !== 9'h1FF) begin n_errors++; $display("FAIL rstmid_oe_pre: got %h expected 1ff", oe[8:0]); end
        n_checks++;
        if (n_done - d0 !== 0 || n_short - s0 !== 0) begin
            n_errors++; $display("FAIL rstmid_pulses: got done=%0d short=%0d expected 0 and 0",
                                 n_done - d0, n_short - s0);
        end
        spi_frame(16, 1'b0, -1, '0, -1, cap, oe, da, sa);
        n_checks++;
        if (word_of(cap) !== model_word(m_pend) || da !== 4) begin
            n_errors++; $display("FAIL rstmid_next: got %h done_at=%0d expected %h done_at=4",
                                 word_of(cap), da, model_word(m_pend));
        end
    endtask

    task automatic test_random;
        logic [31:0] cap, oe; int da, sa, nbits, wr_bit;
        logic [12:0] t, wv; logic [15:0] w; bit coinc;
        for (int it = 0; it < 12; it++) begin
            t      = 13'($urandom);
            wv     = 13'($urandom);
            nbits  = $urandom_range(1, 20);
            wr_bit = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nbits - 1) : -1;
            coinc  = 1'($urandom_range(0, 1));
            write_temp(t);
            w = model_word(m_pend);
            spi_frame(nbits, coinc, wr_bit, wv, -1, cap, oe, da, sa);
            n_checks++;
            if (cap !== model_bits(w, nbits)) begin
                n_errors++; $display("FAIL rand%0d_bits: got %h expected %h (n=%0d)", it, cap,
                                     model_bits(w, nbits), nbits);
            end
            n_checks++;
            if (da !== ((nbits >= 16) ? 4 : 0) || sa !== ((nbits < 16) ? 4 : 0)) begin
                n_errors++; $display("FAIL rand%0d_pulse: got done_at=%0d short_at=%0d n=%0d",
                                     it, da, sa, nbits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_value(13'h0190, 16'h0C84, "nominal");
        test_value(13'h1F38, 16'hF9C4, "negative");
        test_latency();
        test_midframe_write();
        test_short();
        test_coincident();
        test_overclock();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tmp121_spi_slave.md
# tmp121_spi_slave

Synthesizable SPI responder that emulates the TMP121 temperature sensor on the FPGA side, so that our SPI temperature-reader master can be exercised on-board in loopback, without the physical sensor. It oversamples the master's `csn`/`sck` in the `clk` domain and serialises a 16-bit sensor frame onto `miso`. The frame is a 13-bit two's-complement temperature, MSB first, followed by 3 status bits. Temperature is written through a simple register port; a write never tears a frame in progress.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `csn`/`sck` before edge detection; legal range 2..4.
- `TAIL_BITS`, default 3'b100: constant bits 2:0 appended after the temperature.
- `clk`  in  1  system clock, 100 MHz; SPI pins are asynchronous to it.
- `rst`  in  1  reset, synchronous, active-high.
- `csn`  in  1  SPI chip select from the master, active-low, asynchronous.
- `sck`  in  1  SPI clock from the master, idle low, ≤ 1/16 of `clk` frequency.
- `miso`  out  1  serial data to the master; valid while `miso_oe`=1.
- `miso_oe`  out  1  output enable (1 while selected); drives the top-level tristate.
- `temp_in`  in  13  temperature value to present, two's complement, 0.0625 °C/LSB.
- `temp_we`  in  1  single-cycle write strobe for `temp_in`.
- `frame_done`  out  1  single-cycle pulse when `csn` deasserts after ≥16 shifted bits.
- `frame_short`  out  1  single-cycle pulse when `csn` deasserts after <16 shifted bits.

## Operation
- Registers:
  - `pend`: 13 bits. Written by `temp_we`.
  - `shr`: 16 bits. Transmit shift register.
  - `bcnt`: 5 bits. Count of shifted bits, saturating at 16.
  - `state`.
- Synchronised `csn_s`/`sck_s` feed edge detectors, producing `cs_fall`, `cs_rise` and `sck_fall`.
- States:
  - IDLE: `miso_oe`=0, `miso`=0. On `cs_fall`: load `shr`←{`pend`,`TAIL_BITS`}, clear `bcnt`, go to SHIFT.
  - SHIFT: `miso`=`shr[15]`, `miso_oe`=1. On `sck_fall`: shift `shr` left with 0 fill and increment `bcnt`. When `bcnt` reaches 16, go to TAIL.
  - TAIL: `miso`=0, `miso_oe`=1. Further `sck_fall` edges are ignored.
  - On `cs_rise` from SHIFT or TAIL: go to IDLE and pulse `frame_done` if `bcnt`==16, otherwise pulse `frame_short`.
- The master samples on rising `sck`. Data changes only on falling `sck`, so bit 15 is presented before the first rising edge.
- `sck_fall` in the same cycle as `cs_fall` is ignored; the load takes priority. Our master's `csn` fall coincides with an `sck` fall.
- `cs_rise` in the same cycle as `sck_fall` is handled as frame end; the shift is discarded.
- `temp_we` always writes `pend`, in any state. The new value appears in the next frame only; `shr` is never reloaded mid-frame.
- `temp_we` in the same cycle as `cs_fall`: the load uses the old `pend`.
- `rst` asserted mid-frame: return to IDLE immediately and emit no `frame_done`/`frame_short` pulse. Frames already in progress when `rst` releases are ignored until `csn` is next seen high.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `frame_done`=0, `frame_short`=0, `pend`=0, `shr`=0, `bcnt`=0, state IDLE.
- The edge-detect flag asserts SYNC_STAGES+1 clocks after a pin transition. `miso`/`miso_oe` update one clock later (registered): total SYNC_STAGES+2 clocks, 4 at default.
- Budget: the master's first rising `sck` arrives 16 clk after `csn` fall, and each bit is held 32 clk. The ≤6-clk worst-case latency meets this with margin.
- `frame_done`/`frame_short` pulse SYNC_STAGES+2 clocks after the `csn` rising pin edge.
- `temp_we`→`pend` takes 1 clock.

## Structure
- Package `tmp121_pkg`:
  - `TEMP_W`=13
  - `FRAME_BITS`=16
  - `DEFAULT_TAIL`=3'b100
  - state enum {IDLE, SHIFT, TAIL}
- One sub-module, `sync_edge`, instantiated twice (for `csn` and `sck`):
  - Parameter: SYNC_STAGES.
  - Inputs: `clk`, `rst`, async `d`.
  - Outputs: `q`, `rise`, `fall`.
  - Reset level: `csn` instance resets to 1 and `sck` instance resets to 0, so that reset never produces a spurious edge.
- Top: FSM, `shr`, `bcnt`, `pend`.

## Test plan
- Nominal frame: write `temp_in`=13'h0190 (+25.0 °C), then a master-model frame at sck=3.125 MHz with `csn` low for 512 clk. Expect captured word 16'h0C84, `frame_done` pulses once, `frame_short` stays 0.
- Negative value: `temp_in`=13'h1F38 (−12.5 °C). Expect captured word 16'hF9C4, and the upper 13 bits read back as 13'h1F38.
- Mid-frame write: start a frame with `pend`=13'h0010 and write 13'h0FFF after bit 5. Expect the current frame to carry 13'h0010 and the next frame to carry 13'h0FFF.
- Short frame: `csn` high after 7 `sck` periods. Expect `frame_short`=1 pulse and no `frame_done`, then a full frame immediately after that delivers the correct word.
- Coincident edges and over-clocking:
  - `csn` fall in the same clk as an `sck` fall: bit 15 must be held, with no premature shift.
  - 20 `sck` periods in one frame: bits 16–19 read 0, and `frame_done` still pulses.
- Reset mid-frame: `rst` for 1 clk after bit 8, with `csn` staying low. Expect `miso_oe`=0 and no `frame_done`/`frame_short` pulse. The next full frame after `csn` cycles high→low is correct.
